// File: rtl/pwm4zybo_pkg.sv
// Shared definitions for the pwm4zybo PWM core and its AXI4-Lite register slave.
package pwm4zybo_pkg;

  // Default geometry of the core
  localparam int NUM_CH_DEF  = 4;
  localparam int CNT_W_DEF   = 16;
  localparam int PRESC_W_DEF = 16;

  // Core run state
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

  // Reset values of the shadow fields
  localparam logic SH_ENABLE_RST   = 1'b0;
  localparam logic SH_INVERT_RST   = 1'b0;
  localparam int   SH_PRESCALE_RST = 0;
  localparam int   SH_PERIOD_RST   = 0;
  localparam int   SH_DUTY_RST     = 0;

  // Control register layout shared with the AXI slave:
  // run bit 0, enable [4:1], invert [8:5], update bit 9
  typedef struct packed {
    logic [21:0] rsvd;
    logic        update;
    logic [3:0]  invert;
    logic [3:0]  enable;
    logic        run;
  } ctrl_reg_t;

  // Output level of one channel: inactive level when disabled, else compare result with polarity applied
  function automatic logic pwm_level(input logic en, input logic inv, input logic raw);
    if (en) begin
      return raw ^ inv;
    end else begin
      return inv;
    end
  endfunction

endpackage

// File: rtl/pwm4zybo_chan.sv
// One PWM compare channel: shadow duty/enable/invert plus the registered output.
module pwm4zybo_chan
  import pwm4zybo_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic [CNT_W-1:0] cnt,
  input  logic             boundary_load,
  input  logic             idle_load,
  input  logic             cmp_en,
  input  logic             cfg_enable,
  input  logic             cfg_invert,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             pwm_out
);

  logic             sh_enable_r;
  logic             sh_invert_r;
  logic [CNT_W-1:0] sh_duty_r;
  logic             raw_s;
  logic             pwm_d_s;
  logic             pwm_r;

  // Shadow config: follows live config while idle, reloads only at a period boundary while running
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sh_enable_r <= SH_ENABLE_RST;
      sh_invert_r <= SH_INVERT_RST;
      sh_duty_r   <= CNT_W'(SH_DUTY_RST);
    end else if (idle_load || boundary_load) begin
      sh_enable_r <= cfg_enable;
      sh_invert_r <= cfg_invert;
      sh_duty_r   <= cfg_duty;
    end else begin
      sh_enable_r <= sh_enable_r;
      sh_invert_r <= sh_invert_r;
      sh_duty_r   <= sh_duty_r;
    end
  end

  // Compare: duty 0 never asserts, duty above the period always asserts
  always_comb begin
    raw_s   = 1'b0;
    pwm_d_s = sh_invert_r;
    raw_s   = (cnt < sh_duty_r);
    if (cmp_en) begin
      pwm_d_s = pwm_level(sh_enable_r, sh_invert_r, raw_s);
    end else begin
      pwm_d_s = sh_invert_r;
    end
  end

  // Registered pin driver, one clock behind the counter
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= pwm_d_s;
    end
  end

  assign pwm_out = pwm_r;

endmodule

// File: rtl/pwm4zybo_core.sv
// PWM core: shared prescaler and period counter feeding NUM_CH compare channels,
// with config double-buffered so changes take effect only at a period boundary.
module pwm4zybo_core
  import pwm4zybo_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cfg_run,
  input  logic [NUM_CH-1:0]       cfg_enable,
  input  logic [NUM_CH-1:0]       cfg_invert,
  input  logic [PRESC_W-1:0]      cfg_prescale,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
  input  logic                    cfg_update,
  output logic                    update_pending,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [CNT_W-1:0]        cnt_value,
  output logic                    period_irq
);

  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRE_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  pwm_state_e         state_r;
  pwm_state_e         state_d_s;
  logic [PRESC_W-1:0] pre_cnt_r;
  logic [PRESC_W-1:0] pre_cnt_d_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_d_s;
  logic [PRESC_W-1:0] sh_prescale_r;
  logic [CNT_W-1:0]   sh_period_r;
  logic               pending_r;
  logic               pending_d_s;
  logic               irq_r;
  logic               run_active_s;
  logic               idle_load_s;
  logic               tick_s;
  logic               boundary_s;
  logic               load_s;

  // Next state: run follows cfg_run; leaving RUN takes effect on the very next edge
  always_comb begin
    state_d_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (cfg_run) begin
          state_d_s = ST_RUN;
        end else begin
          state_d_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cfg_run) begin
          state_d_s = ST_RUN;
        end else begin
          state_d_s = ST_IDLE;
        end
      end
      default: state_d_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_d_s;
    end
  end

  // Strobes: counting only while running and still requested to run, so a stop never completes a period
  always_comb begin
    run_active_s = (state_r == ST_RUN) && cfg_run;
    idle_load_s  = (state_r == ST_IDLE);
    tick_s       = run_active_s && (pre_cnt_r == sh_prescale_r);
    boundary_s   = tick_s && (cnt_r == sh_period_r);
    load_s       = boundary_s && (pending_r || cfg_update);
  end

  // Next values of prescaler, period counter and pending flag
  always_comb begin
    pre_cnt_d_s = {PRESC_W{1'b0}};
    cnt_d_s     = {CNT_W{1'b0}};
    pending_d_s = 1'b0;
    if (run_active_s) begin
      if (tick_s) begin
        pre_cnt_d_s = {PRESC_W{1'b0}};
        if (boundary_s) begin
          cnt_d_s = {CNT_W{1'b0}};
        end else begin
          cnt_d_s = cnt_r + CNT_ONE;
        end
      end else begin
        pre_cnt_d_s = pre_cnt_r + PRE_ONE;
        cnt_d_s     = cnt_r;
      end
      if (load_s) begin
        pending_d_s = 1'b0;
      end else if (cfg_update) begin
        pending_d_s = 1'b1;
      end else begin
        pending_d_s = pending_r;
      end
    end else begin
      pre_cnt_d_s = {PRESC_W{1'b0}};
      cnt_d_s     = {CNT_W{1'b0}};
      pending_d_s = 1'b0;
    end
  end

  // Counter, pending flag and wrap interrupt registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pre_cnt_r <= {PRESC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      pending_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      pre_cnt_r <= pre_cnt_d_s;
      cnt_r     <= cnt_d_s;
      pending_r <= pending_d_s;
      irq_r     <= boundary_s;
    end
  end

  // Shared timing shadows, loaded under the same rule as the channel shadows
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sh_prescale_r <= PRESC_W'(SH_PRESCALE_RST);
      sh_period_r   <= CNT_W'(SH_PERIOD_RST);
    end else if (idle_load_s || load_s) begin
      sh_prescale_r <= cfg_prescale;
      sh_period_r   <= cfg_period;
    end else begin
      sh_prescale_r <= sh_prescale_r;
      sh_period_r   <= sh_period_r;
    end
  end

  // Compare channels
  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    pwm4zybo_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .cnt          (cnt_r),
      .boundary_load(load_s),
      .idle_load    (idle_load_s),
      .cmp_en       (run_active_s),
      .cfg_enable   (cfg_enable[i]),
      .cfg_invert   (cfg_invert[i]),
      .cfg_duty     (cfg_duty[i*CNT_W +: CNT_W]),
      .pwm_out      (pwm_out[i])
    );
  end

  assign cnt_value      = cnt_r;
  assign update_pending = pending_r;
  assign period_irq     = irq_r;

endmodule

// File: tb/tb_pwm4zybo_core.sv
// Self-checking bench for pwm4zybo_core: directed steps plus random traffic,
// compared each clock against an elapsed-time reference model.
module tb_pwm4zybo_core;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int PRESC_W = 16;

  logic                    tb_ACLK = 1'b0;
  logic                    ARESETN;
  logic                    cfg_run;
  logic [NUM_CH-1:0]       cfg_enable;
  logic [NUM_CH-1:0]       cfg_invert;
  logic [PRESC_W-1:0]      cfg_prescale;
  logic [CNT_W-1:0]        cfg_period;
  logic [NUM_CH*CNT_W-1:0] cfg_duty;
  logic                    cfg_update;
  logic                    update_pending;
  logic [NUM_CH-1:0]       pwm_out;
  logic [CNT_W-1:0]        cnt_value;
  logic                    period_irq;

  int errors = 0;
  int checks = 0;

  // reference model: time since current parameter set took effect
  bit              m_run;
  int              m_t;
  bit              m_pend;
  int              m_pre;
  int              m_per;
  int              m_duty [NUM_CH];
  bit [NUM_CH-1:0] m_en;
  bit [NUM_CH-1:0] m_inv;
  logic [NUM_CH-1:0] e_pwm;
  int              e_cnt;
  bit              e_irq;

  always #5 tb_ACLK = ~tb_ACLK;

  pwm4zybo_core #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W)
  ) dut (
    .ACLK          (tb_ACLK),
    .ARESETN       (ARESETN),
    .cfg_run       (cfg_run),
    .cfg_enable    (cfg_enable),
    .cfg_invert    (cfg_invert),
    .cfg_prescale  (cfg_prescale),
    .cfg_period    (cfg_period),
    .cfg_duty      (cfg_duty),
    .cfg_update    (cfg_update),
    .update_pending(update_pending),
    .pwm_out       (pwm_out),
    .cnt_value     (cnt_value),
    .period_irq    (period_irq)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cur_cnt();
    return (m_t / (m_pre + 1)) % (m_per + 1);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_pend = 1'b0;
    m_pre = 0; m_per = 0; m_en = '0; m_inv = '0;
    for (int i = 0; i < NUM_CH; i++) m_duty[i] = 0;
    e_pwm = '0; e_cnt = 0; e_irq = 1'b0;
  endtask

  task automatic model_load();
    m_pre = int'(cfg_prescale);
    m_per = int'(cfg_period);
    m_en  = cfg_enable;
    m_inv = cfg_invert;
    for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(cfg_duty[i*CNT_W +: CNT_W]);
  endtask

  // one clock of the behavioural model using the inputs currently applied
  task automatic model_step();
    int c;
    if (!m_run) begin
      e_pwm = m_inv; e_irq = 1'b0; m_pend = 1'b0;
      model_load();
      if (cfg_run) begin
        m_run = 1'b1; m_t = 0;
      end
    end else if (!cfg_run) begin
      e_pwm = m_inv; e_irq = 1'b0; m_pend = 1'b0; m_run = 1'b0; m_t = 0;
    end else begin
      c = cur_cnt();
      for (int i = 0; i < NUM_CH; i++)
        e_pwm[i] = m_en[i] ? ((c < m_duty[i]) ^ m_inv[i]) : m_inv[i];
      m_t++;
      e_irq = (m_t % ((m_pre + 1) * (m_per + 1))) == 0;
      if (e_irq && (m_pend || cfg_update)) begin
        model_load(); m_t = 0; m_pend = 1'b0;
      end else if (cfg_update) begin
        m_pend = 1'b1;
      end
    end
    e_cnt = m_run ? cur_cnt() : 0;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge tb_ACLK);
    #1;
    chk({tag, ".cnt"}, 64'(cnt_value), 64'(e_cnt));
    chk({tag, ".pwm"}, 64'(pwm_out), 64'(e_pwm));
    chk({tag, ".irq"}, 64'(period_irq), 64'(e_irq));
    chk({tag, ".pend"}, 64'(update_pending), 64'(m_pend));
  endtask

  task automatic set_duty(input int ch, input int v);
    cfg_duty[ch*CNT_W +: CNT_W] = v[CNT_W-1:0];
  endtask

  task automatic pulse_update(input string tag);
    cfg_update = 1'b1;
    tick(tag);
    cfg_update = 1'b0;
  endtask

  task automatic run_to_cnt(input int target, input string tag);
    int guard = 0;
    while (!(m_run && e_cnt == target) && guard < 200) begin
      tick(tag);
      guard++;
    end
    chk({tag, ".reach"}, 64'(e_cnt), 64'(target));
  endtask

  initial begin
    int first;
    int highs;
    int irqs;
    model_reset();
    ARESETN = 1'b0; cfg_run = 1'b1; cfg_enable = 4'b0001; cfg_invert = 4'b0000;
    cfg_prescale = 16'd1; cfg_period = 16'd3; cfg_duty = 64'd0; cfg_update = 1'b0;
    set_duty(0, 2);

    // reset held while run requested
    repeat (3) @(posedge tb_ACLK);
    #1;
    chk("rst.pwm", 64'(pwm_out), 64'd0);
    chk("rst.cnt", 64'(cnt_value), 64'd0);
    chk("rst.irq", 64'(period_irq), 64'd0);
    chk("rst.pend", 64'(update_pending), 64'd0);
    ARESETN = 1'b1;

    // first irq (period+1)*(prescale+1) clocks after the first RUN cycle
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      tick("first");
      if (period_irq === 1'b1) first = k;
    end
    chk("first_irq_clk", 64'(first), 64'(4 * 2 + 1));

    // basic 30% PWM
    cfg_run = 1'b0; tick("stop0"); tick("stop0");
    cfg_prescale = 16'd0; cfg_period = 16'd9; cfg_enable = 4'b0001; cfg_duty = 64'd0;
    set_duty(0, 3); cfg_run = 1'b1;
    repeat (25) tick("basic");
    highs = 0; irqs = 0;
    for (int k = 0; k < 10; k++) begin
      tick("basic");
      if (pwm_out[0] === 1'b1) highs++;
      if (period_irq === 1'b1) irqs++;
    end
    chk("basic.highs", 64'(highs), 64'd3);
    chk("basic.irqs", 64'(irqs), 64'd1);

    // duty extremes, invert, disable
    set_duty(1, 0); set_duty(2, 10); set_duty(3, 5);
    cfg_enable = 4'b1111; cfg_invert = 4'b1000;
    pulse_update("ext.upd");
    repeat (25) tick("ext");
    cfg_enable = 4'b1011;
    pulse_update("dis.upd");
    repeat (25) tick("dis");

    // mid-period duty change
    cfg_enable = 4'b0001; cfg_invert = 4'b0000; set_duty(0, 3);
    pulse_update("mid.prep");
    repeat (12) tick("mid.prep");
    run_to_cnt(2, "mid.wait");
    set_duty(0, 7);
    pulse_update("mid.upd");
    chk("mid.pend_now", 64'(update_pending), 64'd1);
    repeat (25) tick("mid");

    // prescaled timing, prescale change without update ignored
    cfg_prescale = 16'd2; cfg_period = 16'd4;
    pulse_update("psc.upd");
    repeat (40) tick("psc");
    cfg_prescale = 16'd5;
    repeat (30) tick("psc.noupd");

    // drop run mid-period, then restart
    cfg_prescale = 16'd0; cfg_period = 16'd9; cfg_invert = 4'b0110;
    pulse_update("drop.upd");
    run_to_cnt(5, "drop.wait");
    cfg_run = 1'b0;
    tick("drop");
    chk("drop.pwm_inv", 64'(pwm_out), 64'(4'b0110));
    tick("drop.idle");
    cfg_run = 1'b1;
    repeat (20) tick("restart");

    // async reset mid-run
    ARESETN = 1'b0;
    #2;
    chk("arst.pwm", 64'(pwm_out), 64'd0);
    chk("arst.cnt", 64'(cnt_value), 64'd0);
    chk("arst.pend", 64'(update_pending), 64'd0);
    model_reset();
    @(posedge tb_ACLK);
    #1;
    ARESETN = 1'b1;
    repeat (15) tick("post_arst");

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(19, 0) == 0) begin
        cfg_prescale = 16'($urandom_range(3, 0));
        cfg_period   = 16'($urandom_range(12, 0));
        cfg_enable   = 4'($urandom_range(15, 0));
        cfg_invert   = 4'($urandom_range(15, 0));
        for (int i = 0; i < NUM_CH; i++) set_duty(i, int'($urandom_range(14, 0)));
      end
      cfg_update = ($urandom_range(7, 0) == 0);
      if (cfg_run) cfg_run = ($urandom_range(99, 0) != 0);
      else cfg_run = ($urandom_range(3, 0) == 0);
      tick("rand");
    end
    cfg_update = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
